// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight producers and picks stall/forward for rs and rt.
// stall and fwd_* are same-cycle combinational; stall holds D and bubbles E, MDU busy is registered.
module hazard_scoreboard #(
    parameter int STAGES  = 3,
    parameter int TW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int FW      = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [4:0]    d_waddr,
    input  logic [TW-1:0] d_tnew,
    input  logic [1:0]    d_md,
    input  logic          d_mdu,
    input  logic          flush,
    output logic          stall,
    output logic [FW-1:0] fwd_rs,
    output logic [FW-1:0] fwd_rt,
    output logic          md_busy
);

    localparam logic [TW-1:0] TUSE_NEVER = '1;

    logic [4:0]    r_addr [1:STAGES];
    logic [TW-1:0] r_tnew [1:STAGES];
    logic [7:0]    r_md_cnt;

    logic [4:0]    w_op   [2];
    logic [TW-1:0] w_tuse [2];
    logic          w_hit  [2];
    logic          w_haz  [2];
    logic [FW-1:0] w_fwd  [2];
    logic          w_adv;

    assign w_op[0]   = d_rs;
    assign w_op[1]   = d_rt;
    assign w_tuse[0] = d_tuse_rs;
    assign w_tuse[1] = d_tuse_rt;

    // Scan from the youngest stage so only the nearest producer of each operand decides.
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            w_hit[o] = 1'b0;
            w_haz[o] = 1'b0;
            w_fwd[o] = '0;
            for (int k = 1; k <= STAGES; k++) begin
                if (!w_hit[o] && (w_op[o] != 5'd0) && (r_addr[k] == w_op[o])) begin
                    w_hit[o] = 1'b1;
                    if ((w_tuse[o] != TUSE_NEVER) && (r_tnew[k] > w_tuse[o])) begin
                        w_haz[o] = 1'b1;
                    end
                    if (r_tnew[k] == '0) begin
                        w_fwd[o] = FW'(k);
                    end
                end
            end
        end
    end

    assign md_busy = (r_md_cnt != 8'd0);
    assign stall   = w_haz[0] | w_haz[1] | (d_mdu & md_busy);
    assign fwd_rs  = w_fwd[0];
    assign fwd_rt  = w_fwd[1];
    assign w_adv   = !stall && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                r_addr[k] <= 5'd0;
                r_tnew[k] <= '0;
            end
            r_md_cnt <= 8'd0;
        end else begin
            r_addr[1] <= w_adv ? d_waddr : 5'd0;
            r_tnew[1] <= w_adv ? d_tnew  : '0;
            for (int k = 2; k <= STAGES; k++) begin
                r_addr[k] <= r_addr[k-1];
                r_tnew[k] <= (r_tnew[k-1] != '0) ? (r_tnew[k-1] - TW'(1)) : '0;
            end
            // A flushed or stalled multiply/divide never starts the unit.
            if (w_adv && (d_md == 2'b01)) begin
                r_md_cnt <= 8'(MUL_LAT);
            end else if (w_adv && (d_md == 2'b10)) begin
                r_md_cnt <= 8'(DIV_LAT);
            end else if (r_md_cnt != 8'd0) begin
                r_md_cnt <= r_md_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with STAGES=3, TW=2, MUL_LAT=5, DIV_LAT=10.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_waddr;
    logic [1:0] d_tnew;
    logic [1:0] d_md;
    logic       d_mdu;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       md_busy;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(
        .STAGES(3), .TW(2), .MUL_LAT(5), .DIV_LAT(10)
    ) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_waddr(d_waddr), .d_tnew(d_tnew), .d_md(d_md), .d_mdu(d_mdu),
        .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_waddr = 5'd0; d_tnew = 2'd0; d_md = 2'd0; d_mdu = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall); end
        checks++; if (fwd_rs !== 2'd0) begin errors++; $display("FAIL rst_fwd_rs: got %0d want 0", fwd_rs); end
        checks++; if (fwd_rt !== 2'd0) begin errors++; $display("FAIL rst_fwd_rt: got %0d want 0", fwd_rt); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy: got %0b want 0", md_busy); end
        tick();
    endtask

    task automatic test_load_use();
        idle(); d_waddr = 5'd8; d_tnew = 2'd2;
        tick();
        idle(); d_rs = 5'd8; d_tuse_rs = 2'd1;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", stall); end
        tick();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b want 0", stall); end
        checks++; if (fwd_rs !== 2'd0) begin errors++; $display("FAIL lu_fwd_rs: got %0d want 0", fwd_rs); end
        drain();
    endtask

    task automatic test_alu_branch();
        idle(); d_waddr = 5'd9; d_tnew = 2'd1;
        tick();
        idle(); d_rs = 5'd9; d_tuse_rs = 2'd0;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_stall: got %0b want 1", stall); end
        tick();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_release: got %0b want 0", stall); end
        checks++; if (fwd_rs !== 2'd2) begin errors++; $display("FAIL br_fwd_rs: got %0d want 2", fwd_rs); end
        drain();
    endtask

    task automatic test_zero_reg();
        idle(); d_waddr = 5'd0; d_tnew = 2'd2;
        tick();
        idle(); d_rs = 5'd0; d_tuse_rs = 2'd0; d_rt = 5'd0; d_tuse_rt = 2'd0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %0b want 0", stall); end
        checks++; if (fwd_rs !== 2'd0) begin errors++; $display("FAIL zero_fwd_rs: got %0d want 0", fwd_rs); end
        drain();
    endtask

    // Two back-to-back writers of r31, then watch the match walk down and retire.
    task automatic test_nearest();
        idle(); d_waddr = 5'd31; d_tnew = 2'd0;
        tick(); tick();
        idle(); d_rs = 5'd31; d_tuse_rs = 2'd0; d_rt = 5'd31; d_tuse_rt = 2'd0;
        @(negedge clk);
        checks++; if (fwd_rt !== 2'd1) begin errors++; $display("FAIL near_fwd_rt: got %0d want 1", fwd_rt); end
        checks++; if (fwd_rs !== 2'd1) begin errors++; $display("FAIL near_fwd_rs: got %0d want 1", fwd_rs); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL near_stall: got %0b want 0", stall); end
        tick();
        @(negedge clk);
        checks++; if (fwd_rt !== 2'd2) begin errors++; $display("FAIL near_fwd_m: got %0d want 2", fwd_rt); end
        tick();
        @(negedge clk);
        checks++; if (fwd_rt !== 2'd3) begin errors++; $display("FAIL near_fwd_w: got %0d want 3", fwd_rt); end
        tick();
        @(negedge clk);
        checks++; if (fwd_rt !== 2'd0) begin errors++; $display("FAIL near_retired: got %0d want 0", fwd_rt); end
        drain();
    endtask

    // Chained ALU ops: rt hazard stalls while rs still forwards from M.
    task automatic test_back_to_back();
        idle(); d_waddr = 5'd3; d_tnew = 2'd1;
        tick();
        idle(); d_waddr = 5'd4; d_tnew = 2'd1; d_rs = 5'd3; d_tuse_rs = 2'd1;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_first_stall: got %0b want 0", stall); end
        tick();
        idle(); d_rs = 5'd3; d_tuse_rs = 2'd0; d_rt = 5'd4; d_tuse_rt = 2'd0;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %0b want 1", stall); end
        checks++; if (fwd_rs !== 2'd2) begin errors++; $display("FAIL b2b_fwd_rs: got %0d want 2", fwd_rs); end
        checks++; if (fwd_rt !== 2'd0) begin errors++; $display("FAIL b2b_fwd_rt: got %0d want 0", fwd_rt); end
        drain();
    endtask

    task automatic test_mdu();
        idle(); d_md = 2'b01; d_mdu = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            idle(); d_mdu = 1'b1;
            @(negedge clk);
            checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL mdu_busy_c%0d: got %0b want 1", c, md_busy); end
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mdu_stall_c%0d: got %0b want 1", c, stall); end
            tick();
        end
        @(negedge clk);
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mdu_busy_c6: got %0b want 0", md_busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mdu_stall_c6: got %0b want 0", stall); end
        drain();
    endtask

    task automatic test_flush();
        idle(); d_waddr = 5'd10; d_tnew = 2'd2; flush = 1'b1; d_md = 2'b10; d_mdu = 1'b1;
        tick();
        idle(); d_rs = 5'd10; d_tuse_rs = 2'd0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", stall); end
        checks++; if (fwd_rs !== 2'd0) begin errors++; $display("FAIL flush_fwd_rs: got %0d want 0", fwd_rs); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL flush_md_busy: got %0b want 0", md_busy); end
        drain();
    endtask

    task automatic test_reset_mid();
        idle(); d_md = 2'b10; d_mdu = 1'b1;
        tick();
        idle(); d_waddr = 5'd8; d_tnew = 2'd2;
        tick();
        idle(); d_rs = 5'd8; d_tuse_rs = 2'd1;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %0b want 1", stall); end
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %0b want 1", md_busy); end
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        d_rt = 5'd8; d_tuse_rt = 2'd0; d_mdu = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %0b want 0", stall); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b want 0", md_busy); end
        checks++; if (fwd_rs !== 2'd0) begin errors++; $display("FAIL mid_fwd_rs: got %0d want 0", fwd_rs); end
        drain();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_alu_branch();
        test_zero_reg();
        test_nearest();
        test_back_to_back();
        test_mdu();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- STAGES, 3: tracked producer stages after D (1=E, 2=M, 3=W).
- TW, 2: Tnew/Tuse field width; all-ones Tuse means "never read".
- MUL_LAT, 5: multiply/multu busy cycles.
- DIV_LAT, 10: div/divu busy cycles.
- FW, $clog2(STAGES+1): forward-select width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- d_rs, in, 5: D-stage rs field.
- d_rt, in, 5: D-stage rt field.
- d_tuse_rs, in, TW: cycles until rs is consumed.
- d_tuse_rt, in, TW: cycles until rt is consumed.
- d_waddr, in, 5: destination register of the D instruction; 0 = none.
- d_tnew, in, TW: cycles the result needs after the instruction enters E.
- d_md, in, 2: 00 none, 01 mult/multu, 10 div/divu, 11 treated as none.
- d_mdu, in, 1: D instruction accesses HI/LO (md, mt or mf).
- flush, in, 1: discard the D instruction.
- stall, out, 1: hold PC and the D register; bubble E.
- fwd_rs, out, FW: D-stage rs source; 0 = GRF, k = stage k.
- fwd_rt, out, FW: D-stage rt source; same encoding as fwd_rs.
- md_busy, out, 1: MDU countdown is nonzero.

REQ-003 The stall, fwd_rs and fwd_rt outputs SHALL be combinational from the inputs and registered state, with zero-cycle latency.

Function
REQ-004 The block SHALL hold STAGES entries {addr[4:0], tnew[TW-1:0]}; an entry with addr=0 is a bubble.
REQ-005 On each clock edge the entries SHALL update as follows:
- entry[k] <= entry[k-1] with tnew decremented, saturating at 0, for k = 2..STAGES;
- entry[STAGES] is retired;
- entry[1] <= {d_waddr, d_tnew} when the D instruction advances, else a bubble.
REQ-006 "Advance" SHALL mean stall=0 and flush=0; flush=1 SHALL insert a bubble into entry[1] even when stall=1, and older entries SHALL still shift.
REQ-007 For each operand, matching SHALL use the lowest-k non-bubble entry with addr equal to the operand field (the nearest producer); operand field 0 SHALL never match.
REQ-008 For each operand, the matched entry SHALL set the outputs as follows:
- tnew > tuse: assert stall;
- tnew == 0: fwd = k;
- 0 < tnew <= tuse: no stall, fwd = 0 (downstream forwarding resolves it);
- no match: fwd = 0.
REQ-009 A Tuse of all-ones SHALL never cause a stall.
REQ-010 stall SHALL be the OR of the rs hazard, the rt hazard, and (d_mdu & md_busy).
REQ-011 While stall=1, fwd_rs and fwd_rt SHALL still reflect the REQ-008 result.
REQ-012 The MDU counter SHALL be 8 bits wide and update as follows:
- load MUL_LAT when the D instruction advances with d_md=01;
- load DIV_LAT when the D instruction advances with d_md=10;
- otherwise decrement toward 0, saturating.
REQ-013 md_busy SHALL equal (counter != 0) and SHALL be registered.
REQ-014 flush SHALL NOT alter the MDU counter; a flushed md instruction SHALL NOT load it.
REQ-015 A load and a decrement in the same cycle are impossible by construction (REQ-010); the load SHALL take priority if they coincide.
REQ-016 Both rs and rt hazards SHALL be evaluated independently; when rs = rt, both outputs SHALL be identical.

Reset
REQ-017 When reset=1 at a clock edge, all entries SHALL become bubbles and the MDU counter SHALL become 0.
REQ-018 In the cycle after reset: stall=0, fwd_rs=0, fwd_rt=0, md_busy=0.
REQ-019 Reset SHALL override flush, stall and any in-flight count, including mid-multiply or mid-stall.

Verification (STAGES=3, TW=2, MUL_LAT=5)
REQ-020 Load-use: issue waddr=8, tnew=2; next cycle D rs=8, tuse_rs=1 -> stall=1; following cycle -> stall=0, fwd_rs=0.
REQ-021 ALU-to-branch: issue waddr=9, tnew=1; next cycle rs=9, tuse_rs=0 -> stall=1; following cycle -> stall=0, fwd_rs=2.
REQ-022 Register zero and nearest producer:
- waddr=0, tnew=2, then rs=0, tuse=0 -> stall=0, fwd_rs=0;
- two consecutive jal (waddr=31, tnew=0), then rt=31 -> fwd_rt=1.
REQ-023 MDU: mult advances (d_md=01) -> md_busy=1 for exactly 5 cycles; an mflo (d_mdu=1) presented in those cycles -> stall=1, released in cycle 6.
REQ-024 Flush: flush=1 with waddr=10, tnew=2; next cycle rs=10, tuse=0 -> stall=0, fwd_rs=0.
REQ-025 Reset mid-operation: reset=1 during a DIV_LAT count and an active load-use stall -> next cycle stall=0, md_busy=0, no matches on any register.
